// File: rtl/video_timing_pkg.sv
// Shared video timing constants (720p60 defaults), derived totals and controller state encoding.
package video_timing_pkg;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;
  localparam int FPS_720P      = 60;

  localparam int H_TOTAL_720P = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
  localparam int V_TOTAL_720P = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/hdmi_timing_ctrl_wrap_counter.sv
// Modulo-MOD counter: count is the registered value, count_nxt its value after this edge.
// clr forces zero next edge; wrap flags count == MOD-1 (combinational).
module wrap_counter #(
  parameter int W   = 11,
  parameter int MOD = 1650
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = (count == LAST);

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (en) begin
      count_nxt = wrap ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Video raster timing generator: all outputs registered and decoded from the same next position,
// so flags always describe the hcount/vcount shown alongside them; en_in low freezes everything.
module hdmi_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int H_FP     = H_FP_720P,
  parameter int H_SYNC   = H_SYNC_720P,
  parameter int H_BP     = H_BP_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P,
  parameter int V_FP     = V_FP_720P,
  parameter int V_SYNC   = V_SYNC_720P,
  parameter int V_BP     = V_BP_720P,
  parameter int FPS      = FPS_720P
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [5:0]  FC_LAST   = 6'(FPS - 1);

  state_t      state, state_nxt;
  logic        adv, clr, run_nxt, nf_nxt;
  logic        h_wrap, v_wrap_unused;
  logic [10:0] h_nxt;
  logic [9:0]  v_nxt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        clr = 1'b1;
        if (en_in) state_nxt = RUN;
      end
      RUN: begin
        adv = en_in;
      end
      default: state_nxt = IDLE;
    endcase
  end

  wrap_counter #(.W(11), .MOD(H_TOTAL)) u_hcnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clr       (clr),
    .en        (adv),
    .count     (hcount_out),
    .count_nxt (h_nxt),
    .wrap      (h_wrap)
  );

  wrap_counter #(.W(10), .MOD(V_TOTAL)) u_vcnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clr       (clr),
    .en        (adv && h_wrap),
    .count     (vcount_out),
    .count_nxt (v_nxt),
    .wrap      (v_wrap_unused)
  );

  // Flags are decoded from the position the counters will hold after this edge.
  assign run_nxt = (state_nxt == RUN);
  assign nf_nxt  = adv && (h_nxt == H_ACT_END) && (v_nxt == V_ACT_END);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      ad_out <= 1'b0;
      nf_out <= 1'b0;
      fc_out <= '0;
    end else begin
      hs_out <= run_nxt && (h_nxt >= HS_START) && (h_nxt < HS_END);
      vs_out <= run_nxt && (v_nxt >= VS_START) && (v_nxt < VS_END);
      ad_out <= run_nxt && (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
      nf_out <= nf_nxt;
      if (nf_nxt) fc_out <= (fc_out == FC_LAST) ? '0 : fc_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Randomized enable/reset stimulus against a linear-pixel-index raster model, checked by a scoreboard.
module tb_hdmi_timing_ctrl;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 4;
  localparam int VA = 6, VF = 1, VSW = 2, VB = 2;
  localparam int FPS = 4;
  localparam int HT  = HA + HF + HSW + HB;
  localparam int VT  = VA + VF + VSW + VB;
  localparam int FT  = HT * VT;
  localparam int NFP = VA * HT + HA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hs, vs, ad, nf;
  logic [5:0]  fc;

  hdmi_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .FPS(FPS)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .en_in      (en),
    .hcount_out (hcount),
    .vcount_out (vcount),
    .hs_out     (hs),
    .vs_out     (vs),
    .ad_out     (ad),
    .nf_out     (nf),
    .fc_out     (fc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    int hs;
    int vs;
    int ad;
    int nf;
    int fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: position kept as a single pixel index within the frame.
  bit m_running = 1'b0;
  int m_p  = 0;
  int m_fc = 0;

  task automatic step(input bit r, input bit e);
    exp_t x;
    int   h, v;
    bit   pulse;
    @(negedge clk);
    rst   = r;
    en    = e;
    pulse = 1'b0;
    if (r) begin
      m_running = 1'b0;
      m_p  = 0;
      m_fc = 0;
    end else if (!m_running) begin
      if (e) begin
        m_running = 1'b1;
        m_p = 0;
      end
    end else if (e) begin
      m_p   = (m_p + 1) % FT;
      pulse = (m_p == NFP);
      if (pulse) m_fc = (m_fc + 1) % FPS;
    end
    h    = m_p % HT;
    v    = m_p / HT;
    x.h  = h;
    x.v  = v;
    x.hs = (m_running && h >= HA + HF && h < HA + HF + HSW) ? 1 : 0;
    x.vs = (m_running && v >= VA + VF && v < VA + VF + VSW) ? 1 : 0;
    x.ad = (m_running && h < HA && v < VA) ? 1 : 0;
    x.nf = pulse ? 1 : 0;
    x.fc = m_fc;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("hcount", int'(hcount), x.h);
      chk("vcount", int'(vcount), x.v);
      chk("hs",     int'(hs),     x.hs);
      chk("vs",     int'(vs),     x.vs);
      chk("ad",     int'(ad),     x.ad);
      chk("nf",     int'(nf),     x.nf);
      chk("fc",     int'(fc),     x.fc);
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    for (int i = 0; i < 9000; i++) begin
      if (i == 2500) begin
        repeat (10) step(1'b0, 1'b0);
      end else if (i == 5000) begin
        step(1'b1, 1'b1);
      end else begin
        step(($urandom_range(0, 2999) == 0), ($urandom_range(0, 15) != 0));
      end
    end
    step(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
